// File: rtl/roi_scan_pkg.sv
// Shared types and constants for the roi_scan_ctrl host-side scan sequencer.
// Holds the FSM state encoding, default harness widths and the counter-width helper.
package roi_scan_pkg;

    localparam int unsigned DIN_N_DEF  = 256;
    localparam int unsigned DOUT_N_DEF = 256;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STB1,
        RESHIFT,
        STB2,
        UNLOAD,
        RESP
    } roi_state_e;

    // Wide enough to hold the longer phase length itself.
    function automatic int unsigned cnt_width(input int unsigned din_n, input int unsigned dout_n);
        int unsigned m;
        m = (din_n > dout_n) ? din_n : dout_n;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/roi_scan_ctrl_if.sv
// Stimulus request / result response handshake bundle for roi_scan_ctrl.
// The controller uses the slave modport; the stimulus source uses master.
interface roi_scan_ctrl_if
    import roi_scan_pkg::*;
#(
    parameter int unsigned DIN_N  = DIN_N_DEF,
    parameter int unsigned DOUT_N = DOUT_N_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic [DIN_N-1:0]  req_vec;
    logic              resp_valid;
    logic              resp_ready;
    logic [DOUT_N-1:0] resp_vec;

    modport master (
        output req_valid,
        output req_vec,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_vec
    );

    modport slave (
        input  req_valid,
        input  req_vec,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_vec
    );

endinterface

// File: rtl/roi_scan_shreg.sv
// Shift register for the scan sequencer: parallel load, MSB-first serial out with
// rotate, serial-in capture at the LSB, and a registered, gated serial output.
module roi_scan_shreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         rotate,
    input  logic         sin,
    input  logic         oe,
    output logic [W-1:0] q,
    output logic         sout
);

    logic         sin_eff;
    logic [W-1:0] shifted;
    logic [W-1:0] q_nxt;

    assign sin_eff = rotate ? q[W-1] : sin;

    generate
        if (W == 1) begin : g_w1
            assign shifted = sin_eff;
        end else begin : g_wn
            assign shifted = {q[W-2:0], sin_eff};
        end
    endgenerate

    always_comb begin
        q_nxt = q;
        if (load) begin
            q_nxt = load_val;
        end else if (shift) begin
            q_nxt = shifted;
        end
    end

    // sout presents the MSB the register will hold next cycle, so the serial
    // line is a flop output that lines up with the parallel contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            sout <= 1'b0;
        end else begin
            q    <= q_nxt;
            sout <= oe ? q_nxt[W-1] : 1'b0;
        end
    end

endmodule

// File: rtl/roi_scan_ctrl.sv
// Host-side sequencer for the minitest serial harness: load din, strobe, reshift,
// strobe dout, unload do. Optional txn_cnt output under ROI_SCAN_CTRL_TXN_CNT_EN.
module roi_scan_ctrl
    import roi_scan_pkg::*;
#(
    parameter int unsigned DIN_N  = DIN_N_DEF,
    parameter int unsigned DOUT_N = DOUT_N_DEF,
    parameter int unsigned CNT_W  = cnt_width(DIN_N, DOUT_N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    roi_scan_ctrl_if.slave        bus,
    output logic                  stb,
    output logic                  di,
    input  logic                  do_i
`ifdef ROI_SCAN_CTRL_TXN_CNT_EN
    ,
    output logic [15:0]           txn_cnt
`endif
);

    localparam logic [CNT_W-1:0] DIN_LAST  = CNT_W'(DIN_N - 1);
    localparam logic [CNT_W-1:0] DOUT_LAST = CNT_W'(DOUT_N - 1);

    roi_state_e        state;
    roi_state_e        state_d;
    logic [CNT_W-1:0]  cnt;
    logic              phase_last;
    logic              accept;
    logic              din_shift;
    logic              din_oe;
    logic              cap_shift;
    logic              cnt_en;
    logic              stb_d;
    logic [DIN_N-1:0]  din_par_unused;
    logic              cap_sout_unused;
    logic [DOUT_N-1:0] cap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        phase_last = (cnt == ((state == UNLOAD) ? DOUT_LAST : DIN_LAST));
        case (state)
            IDLE:    if (bus.req_valid)  state_d = LOAD;
            LOAD:    if (phase_last)     state_d = STB1;
            STB1:                        state_d = RESHIFT;
            RESHIFT: if (phase_last)     state_d = STB2;
            STB2:                        state_d = UNLOAD;
            UNLOAD:  if (phase_last)     state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // stb and the din serial enable look at state_d so both land in flops
    // that are valid for the whole of the cycle they belong to.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        accept         = (state == IDLE) && bus.req_valid;
        din_shift      = (state == LOAD) || (state == RESHIFT);
        din_oe         = (state_d == LOAD) || (state_d == RESHIFT);
        cap_shift      = (state == UNLOAD);
        stb_d          = (state_d == STB1) || (state_d == STB2);
        cnt_en         = din_shift || cap_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb <= 1'b0;
            cnt <= '0;
        end else begin
            stb <= stb_d;
            if (state_d != state) begin
                cnt <= '0;
            end else if (cnt_en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A full DIN_N rotation during LOAD returns the vector to its loaded
    // alignment, so RESHIFT replays the identical bit order without a reload.
    roi_scan_shreg #(
        .W (DIN_N)
    ) u_din_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (bus.req_vec),
        .shift    (din_shift),
        .rotate   (1'b1),
        .sin      (1'b0),
        .oe       (din_oe),
        .q        (din_par_unused),
        .sout     (di)
    );

    roi_scan_shreg #(
        .W (DOUT_N)
    ) u_cap_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ('0),
        .shift    (cap_shift),
        .rotate   (1'b0),
        .sin      (do_i),
        .oe       (1'b0),
        .q        (cap_q),
        .sout     (cap_sout_unused)
    );

    assign bus.resp_vec = cap_q;

`ifdef ROI_SCAN_CTRL_TXN_CNT_EN
    logic [15:0] txn_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt_q <= '0;
        end else if ((state == RESP) && bus.resp_ready) begin
            txn_cnt_q <= txn_cnt_q + 16'd1;
        end
    end

    assign txn_cnt = txn_cnt_q;
`endif

endmodule
